// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline control slice.
//   pipe_state_t      : stall sequencer FSM encoding (RUN, HAZ_STALL, MEM_WAIT)
//   *_DEFAULT         : default parameter values for pipeline_stall_sequencer
//   CNT_* / NUM_CNT   : indices of the performance counters in the counter bank
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HAZ_STALL = 2'd1,
    MEM_WAIT  = 2'd2
  } pipe_state_t;

  localparam int CNT_W_DEFAULT     = 32;
  localparam int MAX_STALL_DEFAULT = 8;
  localparam int STALL_W_DEFAULT   = 4;

  // Counter bank layout
  localparam int NUM_CNT    = 3;
  localparam int CNT_STALL  = 0;  // cycles with control_flush
  localparam int CNT_MEMW   = 1;  // cycles with pipe_freeze
  localparam int CNT_BRANCH = 2;  // cycles with take_branch

endpackage

// File: rtl/pipeline_stall_sequencer_sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, clears q
//   clr   : synchronous clear, wins over a same-cycle increment
//   inc   : count one event this cycle
//   q     : current count, sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;
  logic [W-1:0] q_next;

  always_comb begin
    q_next = q_reg;
    if (clr) begin
      q_next = '0;
    end else if (inc && (q_reg != {W{1'b1}})) begin
      q_next = q_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/pipeline_stall_sequencer.sv
// Stall / bubble / flush sequencer for the 5-stage MIPS pipeline.
// Consumes raw hazard flags, the ID-stage branch compare and the memory wait,
// and drives the pipeline register freeze/flush controls. Also keeps three
// saturating performance counters and a sticky stall watchdog.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   hz_load_use           : load in ID_EX targets an IF_ID source register
//   hz_branch_dep         : ID branch operand still in flight (EX or MEM load)
//   branch, cmp_equal     : ID-stage branch and its comparator result
//   mem_busy              : memory not ready, freeze the whole pipeline
//   ctr_clear             : clear counters and stall_timeout
//   pc_freeze, IF_ID_freeze, control_flush, pipe_freeze,
//   take_branch, IF_ID_flush : Mealy control outputs (0 while reset)
//   stall_cycles, mem_wait_cycles, branch_taken_cnt : saturating counters
//   stall_timeout         : sticky, stall run reached MAX_STALL
module pipeline_stall_sequencer
  import mips_pipe_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEFAULT,
  parameter int MAX_STALL = MAX_STALL_DEFAULT,
  parameter int STALL_W   = STALL_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hz_load_use,
  input  logic             hz_branch_dep,
  input  logic             branch,
  input  logic             cmp_equal,
  input  logic             mem_busy,
  input  logic             ctr_clear,
  output logic             pc_freeze,
  output logic             IF_ID_freeze,
  output logic             control_flush,
  output logic             pipe_freeze,
  output logic             take_branch,
  output logic             IF_ID_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] mem_wait_cycles,
  output logic [CNT_W-1:0] branch_taken_cnt,
  output logic             stall_timeout
);

  localparam logic [STALL_W-1:0] RUN_LAST = STALL_W'(MAX_STALL - 1);

  pipe_state_t        state_reg, state_next;
  pipe_state_t        ret_state_reg, ret_state_next;
  pipe_state_t        eval_state;
  logic [STALL_W-1:0] run_reg, run_next;
  logic               timeout_reg, timeout_next;
  logic               stall_hit;
  logic               hazard;

  // Ungated control decisions
  logic pc_freeze_c, if_id_freeze_c, control_flush_c;
  logic pipe_freeze_c, take_branch_c, if_id_flush_c;

  always_comb begin
    hazard          = hz_load_use | hz_branch_dep;
    // Once memory is ready again the cycle behaves as the state we left.
    eval_state      = (state_reg == MEM_WAIT) ? ret_state_reg : state_reg;

    state_next      = state_reg;
    ret_state_next  = ret_state_reg;
    run_next        = run_reg;
    stall_hit       = 1'b0;
    pc_freeze_c     = 1'b0;
    if_id_freeze_c  = 1'b0;
    control_flush_c = 1'b0;
    pipe_freeze_c   = 1'b0;
    take_branch_c   = 1'b0;
    if_id_flush_c   = 1'b0;

    if (mem_busy) begin
      pipe_freeze_c  = 1'b1;
      pc_freeze_c    = 1'b1;
      if_id_freeze_c = 1'b1;
      state_next     = MEM_WAIT;
      // Remember where to resume; the stall run count is frozen meanwhile.
      if (state_reg != MEM_WAIT) begin
        ret_state_next = state_reg;
      end
    end else begin
      case (eval_state)
        RUN, HAZ_STALL: begin
          if (hazard) begin
            // Branch operands are not final yet, so no branch decision here.
            pc_freeze_c     = 1'b1;
            if_id_freeze_c  = 1'b1;
            control_flush_c = 1'b1;
            state_next      = HAZ_STALL;
            if (run_reg != {STALL_W{1'b1}}) begin
              run_next = run_reg + 1'b1;
            end
            // Fires only on the step that reaches MAX_STALL, not every cycle after.
            stall_hit = (run_reg == RUN_LAST);
          end else begin
            take_branch_c = branch & cmp_equal;
            if_id_flush_c = branch & cmp_equal;
            state_next    = RUN;
            run_next      = '0;
          end
        end
        default: begin
          state_next = RUN;
          run_next   = '0;
        end
      endcase
    end

    timeout_next = ctr_clear ? 1'b0 : (timeout_reg | stall_hit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= RUN;
      ret_state_reg <= RUN;
      run_reg       <= '0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ret_state_reg <= ret_state_next;
      run_reg       <= run_next;
      timeout_reg   <= timeout_next;
    end
  end

  // Controls are forced low while reset is held so nothing leaks into the pipe.
  assign pc_freeze     = ~reset & pc_freeze_c;
  assign IF_ID_freeze  = ~reset & if_id_freeze_c;
  assign control_flush = ~reset & control_flush_c;
  assign pipe_freeze   = ~reset & pipe_freeze_c;
  assign take_branch   = ~reset & take_branch_c;
  assign IF_ID_flush   = ~reset & if_id_flush_c;
  assign stall_timeout = timeout_reg;

  // Performance counter bank
  logic [NUM_CNT-1:0] cnt_inc;
  logic [CNT_W-1:0]   cnt_q [NUM_CNT];

  always_comb begin
    cnt_inc             = '0;
    cnt_inc[CNT_STALL]  = control_flush;
    cnt_inc[CNT_MEMW]   = pipe_freeze;
    cnt_inc[CNT_BRANCH] = take_branch;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (ctr_clear),
        .inc   (cnt_inc[gi]),
        .q     (cnt_q[gi])
      );
    end
  endgenerate

  assign stall_cycles     = cnt_q[CNT_STALL];
  assign mem_wait_cycles  = cnt_q[CNT_MEMW];
  assign branch_taken_cnt = cnt_q[CNT_BRANCH];

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// Bench for pipeline_stall_sequencer: a default-width instance and a 4-bit
// counter instance share one stimulus stream; a cycle-level behavioural model
// predicts controls, counters and the watchdog.
module tb_pipeline_stall_sequencer;

  localparam int MAX_STALL = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, hz_load_use, hz_branch_dep, branch, cmp_equal, mem_busy, ctr_clear;

  logic        a_pc_fz, a_ifid_fz, a_cflush, a_pipe_fz, a_take, a_ifid_fl, a_to;
  logic [31:0] a_stall, a_memw, a_brt;
  logic        b_pc_fz, b_ifid_fz, b_cflush, b_pipe_fz, b_take, b_ifid_fl, b_to;
  logic [3:0]  b_stall, b_memw, b_brt;

  pipeline_stall_sequencer #(.CNT_W(32), .MAX_STALL(MAX_STALL), .STALL_W(4)) dut (
    .clk(clk), .reset(reset), .hz_load_use(hz_load_use), .hz_branch_dep(hz_branch_dep),
    .branch(branch), .cmp_equal(cmp_equal), .mem_busy(mem_busy), .ctr_clear(ctr_clear),
    .pc_freeze(a_pc_fz), .IF_ID_freeze(a_ifid_fz), .control_flush(a_cflush),
    .pipe_freeze(a_pipe_fz), .take_branch(a_take), .IF_ID_flush(a_ifid_fl),
    .stall_cycles(a_stall), .mem_wait_cycles(a_memw), .branch_taken_cnt(a_brt),
    .stall_timeout(a_to)
  );

  pipeline_stall_sequencer #(.CNT_W(4), .MAX_STALL(MAX_STALL), .STALL_W(4)) dut_sat (
    .clk(clk), .reset(reset), .hz_load_use(hz_load_use), .hz_branch_dep(hz_branch_dep),
    .branch(branch), .cmp_equal(cmp_equal), .mem_busy(mem_busy), .ctr_clear(ctr_clear),
    .pc_freeze(b_pc_fz), .IF_ID_freeze(b_ifid_fz), .control_flush(b_cflush),
    .pipe_freeze(b_pipe_fz), .take_branch(b_take), .IF_ID_flush(b_ifid_fl),
    .stall_cycles(b_stall), .mem_wait_cycles(b_memw), .branch_taken_cnt(b_brt),
    .stall_timeout(b_to)
  );

  // Reference model: event counts since last clear/reset, current stall run length
  longint m_stall, m_memw, m_brt;
  int     m_run;
  bit     m_to;
  int     n_checks = 0;
  int     n_pass   = 0;
  int     cyc      = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic longint sat4(input longint v);
    return (v > 15) ? 15 : v;
  endfunction

  // One clock cycle: apply inputs, check Mealy controls, clock, check registered state.
  task automatic step(input bit rst, input bit lu, input bit bd, input bit br,
                      input bit eq, input bit mb, input bit clr);
    bit hz, e_pipe, e_fz, e_cf, e_tk, hit;
    logic [5:0] exp_ctl;
    @(negedge clk);
    reset = rst; hz_load_use = lu; hz_branch_dep = bd; branch = br;
    cmp_equal = eq; mem_busy = mb; ctr_clear = clr;
    #1;
    hz     = lu | bd;
    e_pipe = !rst && mb;
    e_fz   = !rst && (mb || hz);
    e_cf   = !rst && !mb && hz;
    e_tk   = !rst && !mb && !hz && br && eq;
    exp_ctl = {e_pipe, e_fz, e_fz, e_cf, e_tk, e_tk};
    check("ctl",   {a_pipe_fz, a_pc_fz, a_ifid_fz, a_cflush, a_take, a_ifid_fl}, exp_ctl);
    check("ctl_4", {b_pipe_fz, b_pc_fz, b_ifid_fz, b_cflush, b_take, b_ifid_fl}, exp_ctl);

    @(posedge clk);
    hit = 1'b0;
    if (rst) begin
      m_stall = 0; m_memw = 0; m_brt = 0; m_run = 0; m_to = 0;
    end else begin
      if (clr) begin
        m_stall = 0; m_memw = 0; m_brt = 0;
      end else begin
        m_stall += e_cf; m_memw += e_pipe; m_brt += e_tk;
      end
      if (!mb) begin
        if (hz) begin
          m_run++;
          hit = (m_run == MAX_STALL);
        end else begin
          m_run = 0;
        end
      end
      m_to = clr ? 1'b0 : (m_to | hit);
    end
    #1;
    check("stall_cycles",     a_stall, m_stall);
    check("mem_wait_cycles",  a_memw,  m_memw);
    check("branch_taken_cnt", a_brt,   m_brt);
    check("stall_timeout",    a_to,    m_to);
    check("stall_cycles_4",     b_stall, sat4(m_stall));
    check("mem_wait_cycles_4",  b_memw,  sat4(m_memw));
    check("branch_taken_cnt_4", b_brt,   sat4(m_brt));
    check("stall_timeout_4",    b_to,    m_to);
    $display("cyc %0d rst=%0b lu=%0b bd=%0b br=%0b eq=%0b mb=%0b clr=%0b ctl=%b stall=%0d memw=%0d brt=%0d to=%0b",
             cyc, rst, lu, bd, br, eq, mb, clr, exp_ctl, a_stall, a_memw, a_brt, a_to);
    cyc++;
  endtask

  initial begin
    reset = 1'b1; hz_load_use = 1'b0; hz_branch_dep = 1'b0; branch = 1'b0;
    cmp_equal = 1'b0; mem_busy = 1'b0; ctr_clear = 1'b0;
    m_stall = 0; m_memw = 0; m_brt = 0; m_run = 0; m_to = 0;

    // Reset state
    repeat (2) step(1, 0, 0, 0, 0, 0, 0);

    // Load-use stall for one cycle
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Taken branch, then branch delayed by operand dependency for two cycles
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 1, 0, 0);
    step(0, 0, 1, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);

    // Memory wait in the middle of a stall
    step(0, 1, 0, 0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Watchdog: hazard held 10 cycles, then clear
    repeat (10) step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);

    // Clear while a long stall continues: must not re-arm past MAX_STALL
    repeat (9) step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 1);
    repeat (3) step(0, 0, 1, 0, 0, 0, 0);

    // Saturation of the 4-bit counters, memory wait in the run
    repeat (12) step(0, 1, 0, 0, 0, 0, 0);
    repeat (2) step(0, 1, 0, 0, 0, 1, 0);
    repeat (8) step(0, 1, 0, 0, 0, 0, 0);

    // Reset during memory wait, then normal operation after release
    repeat (2) step(0, 0, 0, 0, 0, 1, 0);
    step(1, 1, 0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);

    // Randomized traffic, with occasional held-hazard bursts
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        int len = $urandom_range(6, 12);
        for (int k = 0; k < len; k++)
          step(0, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), 1'b0);
      end else begin
        step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 29) == 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
